// File: rtl/coin_pulse_conditioner_if.sv
// Signal bundle between the coin-chute front end and its consumer (classifier side).
interface coin_pulse_conditioner_if #(
  parameter int CNT_WIDTH = 20
);
  logic                 coinSensor;
  logic [CNT_WIDTH-1:0] pulseWidth;
  logic                 pulseValid;
  logic                 pulseTooLong;
  logic                 sensorLevel;
  logic                 busy;

  modport master (
    output coinSensor,
    input  pulseWidth, pulseValid, pulseTooLong, sensorLevel, busy
  );

  modport slave (
    input  coinSensor,
    output pulseWidth, pulseValid, pulseTooLong, sensorLevel, busy
  );
endinterface

// File: rtl/coin_pulse_conditioner.sv
// Synchronises and deglitches the coin sensor, then measures each high pulse in cycles,
// strobing accepted widths and flagging over-long pulses.
module coin_pulse_conditioner #(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 4,
  parameter int CNT_WIDTH     = 20,
  parameter int MIN_WIDTH     = 1000,
  parameter int MAX_WIDTH     = 700000
) (
  input logic                     clk,
  input logic                     reset,
  coin_pulse_conditioner_if.slave bus
);

  localparam int                   FW        = $clog2(FILTER_CYCLES + 1);
  localparam logic [FW-1:0]        FILT_LAST = FW'(FILTER_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] WAIT_LAST = CNT_WIDTH'(FILTER_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] MIN_W     = CNT_WIDTH'(MIN_WIDTH);
  localparam logic [CNT_WIDTH-1:0] MAX_W     = CNT_WIDTH'(MAX_WIDTH);
  localparam logic [CNT_WIDTH-1:0] SAT_W     = CNT_WIDTH'(MAX_WIDTH + 1);

  typedef enum logic [1:0] {WAIT_LOW, IDLE, MEASURE, OVERLONG} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [FW-1:0]          filt_q, filt_d;
  logic                   lvl_q, lvl_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0]   pw_q, pw_d;
  logic                   pv_q, pv_d;
  logic                   ptl_q, ptl_d;
  logic                   s;

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= WAIT_LOW;
      sync_q  <= '0;
      filt_q  <= '0;
      lvl_q   <= 1'b0;
      cnt_q   <= '0;
      pw_q    <= '0;
      pv_q    <= 1'b0;
      ptl_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= {sync_q[SYNC_STAGES-2:0], bus.coinSensor};
      filt_q  <= filt_d;
      lvl_q   <= lvl_d;
      cnt_q   <= cnt_d;
      pw_q    <= pw_d;
      pv_q    <= pv_d;
      ptl_q   <= ptl_d;
    end
  end

  always_comb begin
    state_d = state_q;
    filt_d  = filt_q;
    lvl_d   = lvl_q;
    cnt_d   = cnt_q;
    pw_d    = pw_q;
    pv_d    = 1'b0;
    ptl_d   = 1'b0;

    if (s == lvl_q) begin
      filt_d = '0;
    end else if (filt_q == FILT_LAST) begin
      lvl_d  = s;
      filt_d = '0;
    end else begin
      filt_d = filt_q + 1'b1;
    end

    case (state_q)
      // The pulse counter doubles as the low-stability counter here; its exit edge
      // coincides with the filter dropping a level that was high at reset release.
      WAIT_LOW: begin
        if (s) begin
          cnt_d = '0;
        end else if (cnt_q == WAIT_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      IDLE: begin
        if (lvl_q) begin
          cnt_d   = CNT_WIDTH'(1);
          state_d = MEASURE;
        end
      end
      MEASURE: begin
        if (lvl_q) begin
          if (cnt_q == MAX_W) begin
            cnt_d   = SAT_W;
            ptl_d   = 1'b1;
            state_d = OVERLONG;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          if (cnt_q >= MIN_W && cnt_q <= MAX_W) begin
            pw_d = cnt_q;
            pv_d = 1'b1;
          end
          state_d = IDLE;
        end
      end
      OVERLONG: begin
        if (!lvl_q) state_d = IDLE;
      end
      default: state_d = WAIT_LOW;
    endcase
  end

  assign bus.pulseWidth   = pw_q;
  assign bus.pulseValid   = pv_q;
  assign bus.pulseTooLong = ptl_q;
  assign bus.sensorLevel  = lvl_q;
  assign bus.busy         = (state_q == MEASURE) || (state_q == OVERLONG);

endmodule

// File: tb/tb_coin_pulse_conditioner.sv
// Directed bench for coin_pulse_conditioner with scaled-down width limits.
module tb_coin_pulse_conditioner;

  localparam int SYNC = 2;
  localparam int FILT = 4;
  localparam int CW   = 10;
  localparam int MINW = 20;
  localparam int MAXW = 300;
  localparam int LAT  = SYNC + FILT + 1;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;

  int valid_cnt = 0, tl_cnt = 0, both_cnt = 0;
  int valid_cyc = 0, tl_cyc = 0;
  int total = 0, bad = 0;
  int rise_cyc, fall_cyc;
  int model_w;

  coin_pulse_conditioner_if #(.CNT_WIDTH(CW)) ifc ();

  coin_pulse_conditioner #(
    .SYNC_STAGES  (SYNC),
    .FILTER_CYCLES(FILT),
    .CNT_WIDTH    (CW),
    .MIN_WIDTH    (MINW),
    .MAX_WIDTH    (MAXW)
  ) dut (
    .clk  (clk),
    .reset(rst_n),
    .bus  (ifc.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (ifc.pulseValid) begin
        valid_cnt <= valid_cnt + 1;
        valid_cyc <= cyc;
      end
      if (ifc.pulseTooLong) begin
        tl_cnt <= tl_cnt + 1;
        tl_cyc <= cyc;
      end
      if (ifc.pulseValid && ifc.pulseTooLong) both_cnt <= both_cnt + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive_pulse(input int len);
    ifc.coinSensor = 1'b1;
    rise_cyc = cyc;
    repeat (len) tick();
    ifc.coinSensor = 1'b0;
    fall_cyc = cyc;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_width"}, int'(ifc.pulseWidth), 0);
    check({tag, "_valid"}, int'(ifc.pulseValid), 0);
    check({tag, "_toolong"}, int'(ifc.pulseTooLong), 0);
    check({tag, "_level"}, int'(ifc.sensorLevel), 0);
    check({tag, "_busy"}, int'(ifc.busy), 0);
  endtask

  typedef struct {
    int len;
    int exp_valid;
    int exp_tl;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int v0, t0, max_lvl;

    vecs[0] = '{len: 150, exp_valid: 1, exp_tl: 0};
    vecs[1] = '{len: 10,  exp_valid: 0, exp_tl: 0};
    vecs[2] = '{len: 20,  exp_valid: 1, exp_tl: 0};
    vecs[3] = '{len: 19,  exp_valid: 0, exp_tl: 0};
    vecs[4] = '{len: 21,  exp_valid: 1, exp_tl: 0};
    vecs[5] = '{len: 300, exp_valid: 1, exp_tl: 0};
    vecs[6] = '{len: 301, exp_valid: 0, exp_tl: 1};
    vecs[7] = '{len: 5,   exp_valid: 0, exp_tl: 0};

    rst_n = 1'b0;
    ifc.coinSensor = 1'b0;
    model_w = 0;
    repeat (3) tick();
    check_all_zero("in_reset");
    rst_n = 1'b1;
    repeat (3) tick();
    check_all_zero("post_reset");
    repeat (20) tick();

    // Over-long pulse: single tooLong strobe, busy held until the fall, then IDLE
    v0 = valid_cnt; t0 = tl_cnt;
    drive_pulse(400);
    check("long_busy_before_fall", int'(ifc.busy), 1);
    repeat (12) tick();
    check("long_tl_count", tl_cnt - t0, 1);
    check("long_valid_count", valid_cnt - v0, 0);
    check("long_tl_latency", tl_cyc - rise_cyc, LAT + MAXW);
    check("long_busy_after", int'(ifc.busy), 0);
    check("long_width_unchanged", int'(ifc.pulseWidth), model_w);

    for (int unsigned i = 0; i < $size(vecs); i++) begin
      v0 = valid_cnt; t0 = tl_cnt;
      drive_pulse(vecs[i].len);
      repeat (20) tick();
      if (vecs[i].exp_valid != 0) model_w = vecs[i].len;
      check($sformatf("vec%0d_valid_count", i), valid_cnt - v0, vecs[i].exp_valid);
      check($sformatf("vec%0d_tl_count", i), tl_cnt - t0, vecs[i].exp_tl);
      check($sformatf("vec%0d_width", i), int'(ifc.pulseWidth), model_w);
      if (vecs[i].exp_valid != 0)
        check($sformatf("vec%0d_latency", i), valid_cyc - fall_cyc, LAT);
      check($sformatf("vec%0d_busy", i), int'(ifc.busy), 0);
    end

    // 3-cycle glitch must never reach sensorLevel
    v0 = valid_cnt; t0 = tl_cnt;
    max_lvl = 0;
    ifc.coinSensor = 1'b1;
    repeat (3) tick();
    ifc.coinSensor = 1'b0;
    repeat (15) begin
      tick();
      if (ifc.sensorLevel) max_lvl = 1;
    end
    check("glitch_level", max_lvl, 0);
    check("glitch_strobes", (valid_cnt - v0) + (tl_cnt - t0), 0);

    // 2-cycle low dropout inside a pulse is bridged; whole span is measured
    v0 = valid_cnt;
    ifc.coinSensor = 1'b1;
    rise_cyc = cyc;
    repeat (100) tick();
    ifc.coinSensor = 1'b0;
    repeat (2) tick();
    ifc.coinSensor = 1'b1;
    repeat (98) tick();
    ifc.coinSensor = 1'b0;
    fall_cyc = cyc;
    repeat (20) tick();
    model_w = 200;
    check("dropout_valid_count", valid_cnt - v0, 1);
    check("dropout_width", int'(ifc.pulseWidth), model_w);

    // Back-to-back pulses separated by the minimum filterable gap
    v0 = valid_cnt;
    drive_pulse(30);
    repeat (FILT) tick();
    drive_pulse(35);
    repeat (20) tick();
    model_w = 35;
    check("b2b_valid_count", valid_cnt - v0, 2);
    check("b2b_width", int'(ifc.pulseWidth), model_w);

    // Sensor high across reset release is never measured
    ifc.coinSensor = 1'b1;
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    model_w = 0;
    v0 = valid_cnt; t0 = tl_cnt;
    repeat (100) tick();
    check("stuck_level_high", int'(ifc.sensorLevel), 1);
    check("stuck_busy", int'(ifc.busy), 0);
    ifc.coinSensor = 1'b0;
    repeat (20) tick();
    check("stuck_strobes", (valid_cnt - v0) + (tl_cnt - t0), 0);
    check("stuck_width", int'(ifc.pulseWidth), model_w);
    v0 = valid_cnt;
    drive_pulse(250);
    repeat (20) tick();
    model_w = 250;
    check("after_stuck_valid", valid_cnt - v0, 1);
    check("after_stuck_width", int'(ifc.pulseWidth), model_w);

    // Reset mid-pulse clears everything at once and loses the measurement
    ifc.coinSensor = 1'b1;
    repeat (100) tick();
    check("mid_busy_before", int'(ifc.busy), 1);
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_reset");
    repeat (5) tick();
    rst_n = 1'b1;
    v0 = valid_cnt; t0 = tl_cnt;
    repeat (50) tick();
    ifc.coinSensor = 1'b0;
    repeat (20) tick();
    check("mid_strobes", (valid_cnt - v0) + (tl_cnt - t0), 0);
    check("mid_width", int'(ifc.pulseWidth), 0);

    check("strobe_overlap", both_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/coin_pulse_conditioner.md
Name: coin_pulse_conditioner

Overview:
- Front-end stage between the raw coin-chute sensor pin and the coin classifier that feeds the vending-machine credit FSM.
- Synchronises and deglitches `coinSensor`, then measures each coin's high-pulse width in clock cycles.
- Emits one width word per coin with a one-cycle valid strobe, and flags over-long pulses (jammed coin or stuck sensor).
- Pulses that are too short are rejected as noise.

Parameters:
- SYNC_STAGES, 2: flops in the input synchroniser chain (min 2).
- FILTER_CYCLES, 4: consecutive stable cycles required before the filtered level follows the synchronised input.
- CNT_WIDTH, 20: width of the pulse counter and of `pulseWidth`.
- MIN_WIDTH, 1000: shortest accepted pulse, in cycles. Shorter pulses are discarded silently.
- MAX_WIDTH, 700000: longest accepted pulse, in cycles. Must be < 2^CNT_WIDTH - 1.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- coinSensor  in  1  raw asynchronous sensor; high while a coin blocks the beam.
- pulseWidth  out  CNT_WIDTH  width of the last accepted pulse; holds until the next accepted pulse.
- pulseValid  out  1  one-cycle strobe; `pulseWidth` is new this cycle.
- pulseTooLong  out  1  one-cycle strobe; current pulse exceeded MAX_WIDTH.
- sensorLevel  out  1  filtered, synchronised sensor level.
- busy  out  1  high in MEASURE and OVERLONG states.

Behaviour:
- **Reset (reset low, asynchronous):**
  - Synchroniser flops, filter counter, pulse counter, `pulseWidth`, `pulseValid`, `pulseTooLong`, `sensorLevel` and `busy` all go to 0.
  - State goes to WAIT_LOW.
- **Synchroniser:** SYNC_STAGES-deep flop chain. Its output is `s`.
- **Filter:**
  - Stability counter increments each cycle while `s` != `sensorLevel`, and clears to 0 on any cycle where `s` == `sensorLevel`.
  - When the counter reaches FILTER_CYCLES, `sensorLevel` <= `s` and the counter clears.
  - Any excursion of `s` shorter than FILTER_CYCLES cycles never reaches `sensorLevel`.
  - Clean edges are delayed equally, so filtered width equals raw width.
- **State machine (all transitions on posedge clk):**
  - WAIT_LOW:
    - Leave to IDLE only after `s` == 0 for FILTER_CYCLES consecutive cycles.
    - A sensor already high at reset release is therefore never measured as a coin.
  - IDLE:
    - On `sensorLevel` 0->1, go to MEASURE with count = 1.
  - MEASURE, while `sensorLevel` stays 1:
    - count increments each cycle.
    - If count would exceed MAX_WIDTH, assert `pulseTooLong` for exactly one cycle and go to OVERLONG.
    - The counter saturates at MAX_WIDTH+1 and never wraps.
  - MEASURE, on the cycle `sensorLevel` is first 0:
    - If MIN_WIDTH <= count <= MAX_WIDTH, then `pulseWidth` <= count and `pulseValid` = 1 for that one cycle.
    - Otherwise output nothing.
    - In both cases go to IDLE.
    - count equals the number of cycles `sensorLevel` was high.
  - OVERLONG:
    - Stay until `sensorLevel` == 0, then go to IDLE.
    - Assert no `pulseValid` for this pulse.
- **Latency:**
  - Raw coinSensor edge -> `sensorLevel` edge: SYNC_STAGES + FILTER_CYCLES cycles (±1 for asynchronous sampling).
  - Raw falling edge -> `pulseValid`: SYNC_STAGES + FILTER_CYCLES + 1 cycles.
- **Strobe exclusivity:**
  - `pulseValid` and `pulseTooLong` are never high in the same cycle.
  - Each pulse produces at most one strobe in total.
- **Back-to-back pulses:**
  - A new rising `sensorLevel` edge in the cycle right after `pulseValid` is accepted, because IDLE is entered with `sensorLevel` low.
  - The minimum gap is enforced by the filter.
- **Reset mid-pulse:**
  - All outputs clear immediately and the measurement is lost.
  - The block re-enters WAIT_LOW.
- **busy:**
  - 1 in MEASURE and OVERLONG.
  - 0 in WAIT_LOW and IDLE.

Test Plan:
1. Defaults, release reset with coinSensor low, drive a 400000-cycle high pulse -> `pulseValid` high exactly 1 cycle, 7 cycles (±1) after the raw fall, with `pulseWidth` = 400000 (±1). `pulseWidth` holds 400000 afterwards.
2. A 3-cycle high glitch, then a 2-cycle low glitch in the middle of a 500000-cycle pulse -> the first produces no strobe and `sensorLevel` stays 0. The second produces a single `pulseValid` with `pulseWidth` = 500000 (±1).
3. A 500-cycle pulse, then a 1000-cycle pulse -> no strobe for the first. `pulseValid` with `pulseWidth` = 1000 for the second.
4. An 800000-cycle pulse -> `pulseTooLong` for 1 cycle when count passes 700000, `busy` stays high until the fall, no `pulseValid`, then IDLE.
5. Hold coinSensor high through reset release for 10000 cycles, then drop it -> no strobes. A following 600000-cycle pulse gives `pulseValid` with `pulseWidth` = 600000 (±1).
6. Assert reset 200000 cycles into a pulse -> all outputs 0 within the same cycle, and no strobe for that pulse after release.
